// File: rtl/level_coin_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | level_coin_controller                                                      |
// | Coin tiles, tile-map write serialiser and sticky WON/LOST level status.    |
// | Optional score counter enabled by defining LEVEL_SCORE_EN.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module level_coin_controller #(
  parameter int                     NUM_COINS       = 3,
  parameter int                     NUM_HAZARDS     = 2,
  parameter logic [NUM_COINS*5-1:0] COIN_X          = {5'd3, 5'd14, 5'd15},
  parameter logic [NUM_COINS*4-1:0] COIN_Y          = {4'd4, 4'd2, 4'd7},
  parameter int                     NUM_COLS        = 17,
  parameter int                     NUM_ROWS        = 12,
  parameter logic [7:0]             SKY             = 8'd1,
  parameter logic [7:0]             TKN             = 8'd4,
  parameter int                     CHARACTER_WIDTH = 42,
  parameter int                     BLOCK_WIDTH     = 40,
  parameter int                     COIN_POINTS     = 100
) (
  input  logic                           vga_clock,
  input  logic                           reset,
  input  logic signed [31:0]             mario_x,
  input  logic signed [31:0]             mario_y,
  input  logic [NUM_HAZARDS-1:0]         hazard_hit,
  input  logic                           timer_done,
  output logic                           tile_wr_valid,
  input  logic                           tile_wr_ready,
  output logic [4:0]                     tile_wr_x,
  output logic [3:0]                     tile_wr_y,
  output logic [7:0]                     tile_wr_value,
  output logic [$clog2(NUM_COINS+1)-1:0] coins_left,
  output logic [NUM_COINS-1:0]           coin_taken,
  output logic                           win,
  output logic                           lose
`ifdef LEVEL_SCORE_EN
  ,
  output logic [15:0]                    score
`endif
);

  localparam int c_idx_w = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
  localparam int c_cnt_w = $clog2(NUM_COINS + 1);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(NUM_COINS - 1);
  localparam logic [c_cnt_w-1:0] c_num_coins = c_cnt_w'(NUM_COINS);

  if (NUM_COINS < 1 || NUM_COINS > 8 || NUM_HAZARDS < 1 || NUM_HAZARDS > 8 ||
      COIN_POINTS < 0 || COIN_POINTS > 65535) begin : g_param_check
    $error("level_coin_controller: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_PLAYING = 2'd1,
    S_WON     = 2'd2,
    S_LOST    = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_idx_w-1:0]   r_init_idx;
  logic [c_idx_w-1:0]   r_wr_idx;
  logic [NUM_COINS-1:0] r_pending;
  logic [NUM_COINS-1:0] w_touch;
  logic [NUM_COINS-1:0] w_new;
  logic [NUM_COINS-1:0] w_clr;
  logic [NUM_COINS-1:0] w_pend_mask;
  logic [c_idx_w-1:0]   w_sel_idx;
  logic [c_idx_w-1:0]   w_init_next;
  logic                 w_sel_any;
  logic                 w_commit;

  function automatic logic [4:0] f_coin_x(input logic [c_idx_w-1:0] idx);
    f_coin_x = COIN_X[4:0];
    for (int i = 0; i < NUM_COINS; i++)
      if (idx == i[c_idx_w-1:0]) f_coin_x = COIN_X[5*i +: 5];
  endfunction

  function automatic logic [3:0] f_coin_y(input logic [c_idx_w-1:0] idx);
    f_coin_y = COIN_Y[3:0];
    for (int i = 0; i < NUM_COINS; i++)
      if (idx == i[c_idx_w-1:0]) f_coin_y = COIN_Y[4*i +: 4];
  endfunction

  // Map is drawn mirrored: array index 0 sits at the right/bottom edge of the screen.
  for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_coin
    localparam int c_tx = (NUM_COLS - 1 - int'(COIN_X[5*gi +: 5])) * BLOCK_WIDTH;
    localparam int c_ty = (NUM_ROWS - 1 - int'(COIN_Y[4*gi +: 4])) * BLOCK_WIDTH;
    assign w_touch[gi] = (mario_x < c_tx + BLOCK_WIDTH) && (mario_x + CHARACTER_WIDTH > c_tx) &&
                         (mario_y < c_ty + BLOCK_WIDTH) && (mario_y + CHARACTER_WIDTH > c_ty);
  end

  assign w_commit    = tile_wr_valid && tile_wr_ready;
  assign w_new       = (r_state == S_PLAYING) ? (w_touch & ~coin_taken & ~r_pending) : '0;
  assign w_pend_mask = r_pending & ~w_clr;
  assign w_init_next = r_init_idx + c_idx_w'(1);

  always_comb begin
    w_clr     = '0;
    w_sel_any = 1'b0;
    w_sel_idx = '0;
    for (int i = 0; i < NUM_COINS; i++)
      w_clr[i] = w_commit && (r_state != S_INIT) && (r_wr_idx == i[c_idx_w-1:0]);
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (w_pend_mask[i]) begin
        w_sel_any = 1'b1;
        w_sel_idx = i[c_idx_w-1:0];
      end
    end
  end

`ifdef LEVEL_SCORE_EN
  logic [16:0] w_score_sum;
  assign w_score_sum = {1'b0, score} + 17'(COIN_POINTS);
`endif

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_INIT;
      r_init_idx    <= '0;
      r_wr_idx      <= '0;
      r_pending     <= '0;
      coin_taken    <= '0;
      coins_left    <= c_num_coins;
      tile_wr_valid <= 1'b0;
      tile_wr_x     <= '0;
      tile_wr_y     <= '0;
      tile_wr_value <= '0;
      win           <= 1'b0;
      lose          <= 1'b0;
`ifdef LEVEL_SCORE_EN
      score         <= '0;
`endif
    end else if (r_state == S_INIT) begin
      if (!tile_wr_valid) begin
        tile_wr_valid <= 1'b1;
        tile_wr_x     <= f_coin_x(r_init_idx);
        tile_wr_y     <= f_coin_y(r_init_idx);
        tile_wr_value <= TKN;
      end else if (tile_wr_ready) begin
        if (r_init_idx == c_last_idx) begin
          tile_wr_valid <= 1'b0;
          r_state       <= S_PLAYING;
        end else begin
          r_init_idx <= w_init_next;
          tile_wr_x  <= f_coin_x(w_init_next);
          tile_wr_y  <= f_coin_y(w_init_next);
        end
      end
    end else begin
      r_pending <= (r_pending | w_new) & ~w_clr;
      if (w_commit) begin
        coin_taken <= coin_taken | w_clr;
        if ((w_clr & ~coin_taken) != '0) coins_left <= coins_left - c_cnt_w'(1);
`ifdef LEVEL_SCORE_EN
        score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
`endif
      end
      // Output slot reloads only when empty or being consumed, so x/y/value hold under backpressure.
      if (!tile_wr_valid || tile_wr_ready) begin
        tile_wr_valid <= w_sel_any;
        if (w_sel_any) begin
          r_wr_idx      <= w_sel_idx;
          tile_wr_x     <= f_coin_x(w_sel_idx);
          tile_wr_y     <= f_coin_y(w_sel_idx);
          tile_wr_value <= SKY;
        end
      end
      if (r_state == S_PLAYING) begin
        if ((|hazard_hit) || timer_done) begin
          r_state <= S_LOST;
          lose    <= 1'b1;
        end else if (coins_left == '0 && r_pending == '0) begin
          r_state <= S_WON;
          win     <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_level_coin_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_level_coin_controller                                                   |
// | Directed bench for level_coin_controller; score checks under LEVEL_SCORE_EN.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_level_coin_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance 1: coin0=(3,4) coin1=(14,2) coin2=(15,7)
  logic signed [31:0] mario_x, mario_y;
  logic [1:0] hazard;
  logic       timer, ready, valid, win, lose;
  logic [4:0] wx;
  logic [3:0] wy;
  logic [7:0] wv;
  logic [1:0] left;
  logic [2:0] taken;
  // Instance 2: coin0=(5,5) and coin2=(6,5) adjacent, coin1=(10,1)
  logic signed [31:0] m2x, m2y;
  logic [1:0] hazard2;
  logic       ready2, valid2, win2, lose2;
  logic [4:0] wx2;
  logic [3:0] wy2;
  logic [7:0] wv2;
  logic [1:0] left2;
  logic [2:0] taken2;
`ifdef LEVEL_SCORE_EN
  logic [15:0] score, score2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  level_coin_controller #(
    .COIN_X({5'd15, 5'd14, 5'd3}), .COIN_Y({4'd7, 4'd2, 4'd4})
  ) dut (
    .vga_clock(clk), .reset(reset), .mario_x(mario_x), .mario_y(mario_y),
    .hazard_hit(hazard), .timer_done(timer), .tile_wr_valid(valid), .tile_wr_ready(ready),
    .tile_wr_x(wx), .tile_wr_y(wy), .tile_wr_value(wv), .coins_left(left),
    .coin_taken(taken), .win(win), .lose(lose)
`ifdef LEVEL_SCORE_EN
    , .score(score)
`endif
  );

  level_coin_controller #(
    .COIN_X({5'd6, 5'd10, 5'd5}), .COIN_Y({4'd5, 4'd1, 4'd5})
  ) dut2 (
    .vga_clock(clk), .reset(reset), .mario_x(m2x), .mario_y(m2y),
    .hazard_hit(hazard2), .timer_done(1'b0), .tile_wr_valid(valid2), .tile_wr_ready(ready2),
    .tile_wr_x(wx2), .tile_wr_y(wy2), .tile_wr_value(wv2), .coins_left(left2),
    .coin_taken(taken2), .win(win2), .lose(lose2)
`ifdef LEVEL_SCORE_EN
    , .score(score2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic v, input logic [4:0] x,
                        input logic [3:0] y, input logic [7:0] val);
    chk({tag, "_valid"}, valid, v);
    chk({tag, "_x"}, wx, x);
    chk({tag, "_y"}, wy, y);
    chk({tag, "_value"}, wv, val);
  endtask

  initial begin
    reset = 1'b0; ready = 1'b1; ready2 = 1'b1; hazard = '0; hazard2 = '0; timer = 1'b0;
    mario_x = 2000; mario_y = 2000; m2x = 2000; m2y = 2000;
    step(); step();
    chk("rst_valid", valid, 0);
    chk("rst_left", left, 3);
    chk("rst_taken", taken, 0);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);

    // Three TKN writes on consecutive cycles
    reset = 1'b1;
    step(); chk_wr("init0", 1, 3, 4, 4);
    step(); chk_wr("init1", 1, 14, 2, 4);
    step(); chk_wr("init2", 1, 15, 7, 4);
    step(); chk("init_done_valid", valid, 0);
    chk("init_done_left", left, 3);

    // Backpressure during INIT
    reset = 1'b0; #1;
    chk("async_rst_valid", valid, 0);
    ready = 1'b0;
    step(); reset = 1'b1;
    step(); chk_wr("bp_first", 1, 3, 4, 4);
    for (int k = 0; k < 5; k++) begin
      step(); chk_wr("bp_hold", 1, 3, 4, 4);
    end
    ready = 1'b1;
    step(); chk_wr("bp_resume1", 1, 14, 2, 4);
    step(); chk_wr("bp_resume2", 1, 15, 7, 4);
    step(); chk("bp_done_valid", valid, 0);

    // Single coin collection at (14,2)
    mario_x = 80; mario_y = 360;
    step(); chk("c1_capture_valid", valid, 0);
    step(); chk_wr("c1_write", 1, 14, 2, 1);
    step(); chk("c1_valid_after", valid, 0);
    chk("c1_left", left, 2);
    chk("c1_taken", taken, 3'b010);
    step(); chk("c1_no_repeat", valid, 0);
    chk("c1_left_hold", left, 2);
    mario_x = 2000; mario_y = 2000;

    // Simultaneous touch of coins 0 and 2 on instance 2
    m2x = 420; m2y = 240;
    step(); chk("dual_capture_valid", valid2, 0);
    step(); chk("dual_w0_valid", valid2, 1);
    chk("dual_w0_x", wx2, 5); chk("dual_w0_y", wy2, 5); chk("dual_w0_value", wv2, 1);
    m2x = 2000; m2y = 2000;
    step(); chk("dual_w2_valid", valid2, 1);
    chk("dual_w2_x", wx2, 6); chk("dual_w2_y", wy2, 5);
    chk("dual_w2_left", left2, 2);
    step(); chk("dual_done_valid", valid2, 0);
    chk("dual_left", left2, 1);
    chk("dual_taken", taken2, 3'b101);

    // Edge-adjacent without overlap, negative coordinate
    mario_x = -2; mario_y = 160;
    step(); step(); chk("edge_no_touch", valid, 0);

    // Collect remaining coins, then WON is sticky against a hazard
    mario_x = 520; mario_y = 280;
    step(); step(); chk_wr("c0_write", 1, 3, 4, 1);
    mario_x = 40; mario_y = 160;
    step(); chk("c0_left", left, 1);
    chk("c0_valid_after", valid, 0);
    step(); chk_wr("c2_write", 1, 15, 7, 1);
    mario_x = 2000; mario_y = 2000;
    step(); chk("all_left", left, 0);
    chk("all_taken", taken, 3'b111);
    chk("win_not_yet", win, 0);
    step(); chk("win_set", win, 1);
    chk("win_lose0", lose, 0);
    hazard = 2'b01;
    step(); step();
    chk("win_sticky", win, 1);
    chk("win_no_lose", lose, 0);
    hazard = 2'b00;
`ifdef LEVEL_SCORE_EN
    chk("score_300", score, 300);
`endif

    // Hazard in the same cycle as the last commit on instance 2
    m2x = 240; m2y = 400; ready2 = 1'b0;
    step(); step();
    chk("lc_valid", valid2, 1); chk("lc_x", wx2, 10); chk("lc_y", wy2, 1);
    m2x = 2000; m2y = 2000;
    hazard2 = 2'b10; ready2 = 1'b1;
    step();
    chk("lc_lose", lose2, 1);
    chk("lc_win", win2, 0);
    chk("lc_left", left2, 0);
    chk("lc_taken", taken2, 3'b111);
    step();
    chk("lc_win_stays0", win2, 0);
    chk("lc_lose_stays1", lose2, 1);
`ifdef LEVEL_SCORE_EN
    chk("score2_300", score2, 300);
`endif

    // Reset mid-write drops valid immediately
    reset = 1'b0; ready = 1'b0;
    step(); reset = 1'b1;
    step(); chk("mid_valid_pre", valid, 1);
    reset = 1'b0; #1;
    chk("mid_valid_drop", valid, 0);
    chk("mid_win", win, 0);
    chk("mid_left", left, 3);

    // Timer expiry loses the level
    ready = 1'b1;
    step(); reset = 1'b1;
    step(); step(); step(); step();
    chk("tmr_pre_lose", lose, 0);
    timer = 1'b1;
    step();
    chk("tmr_lose", lose, 1);
    chk("tmr_win", win, 0);
    timer = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
